// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types, sizes, weight-map bases and vote helper for the SVM sequencer
package svm_pkg;

    typedef logic [15:0]        T;
    typedef logic signed [15:0] TC;

    localparam int DIMS    = 21;
    localparam int INTER   = 6;
    localparam int CLASSES = 3;

    localparam int W1_BASE = 0;
    localparam int B1_BASE = 126;
    localparam int W2_BASE = 132;
    localparam int B2_BASE = 150;
    localparam int LATENCY = INTER * (DIMS + 1) + 1 + CLASSES * (INTER + 1) + 1 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_L1,
        S_DR1,
        S_L2,
        S_DR2,
        S_VOTE,
        S_OUT
    } state_t;

    // One-vs-one vote over three classes; equal vote counts fall through to the higher class.
    function automatic logic [1:0] vote3(input TC y0, input TC y1, input TC y2);
        logic       g0, g1, g2;
        logic [1:0] v0, v1, v2;
        g0 = y0 > 16'sd0;
        g1 = y1 > 16'sd0;
        g2 = y2 > 16'sd0;
        v0 = {1'b0, g0} + {1'b0, g1};
        v1 = {1'b0, !g0} + {1'b0, g2};
        v2 = {1'b0, !g1} + {1'b0, !g2};
        if (v0 > v1) return (v0 > v2) ? 2'd0 : 2'd2;
        else         return (v1 > v2) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/svm_mac_acc.sv
// rtl/svm_mac_acc.sv - shared 16x16 signed MAC with 32-bit wrapping accumulator
module svm_mac_acc (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en,
    input  logic               load,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic [15:0]        res
);

    logic signed [31:0] acc;
    logic signed [31:0] prod;
    logic signed [31:0] acc_nxt;

    // A load takes the bias word itself, sign-extended, rather than a product.
    assign prod    = a * b;
    assign acc_nxt = load ? {{16{b[15]}}, b} : acc + prod;
    assign res     = acc_nxt[15:0];

    always_ff @(posedge clk_i) begin
        if (rst_i)   acc <= '0;
        else if (en) acc <= acc_nxt;
    end

endmodule

// File: rtl/svm_seq.sv
// rtl/svm_seq.sv - time-multiplexed two-layer SVM sequencer over one shared MAC
module svm_seq
    import svm_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          din_valid_i,
    input  logic [15:0]   din_i,
    output logic          din_ready_o,
    output logic          w_en_o,
    output logic [AW-1:0] w_addr_o,
    input  logic [15:0]   w_rdata_i,
    output logic          class_valid_o,
    output logic [1:0]    class_o,
    input  logic          class_ready_i,
    output logic          busy_o
);

    localparam logic [4:0] CNT_LD = 5'(DIMS - 1);
    localparam logic [4:0] CNT_L1 = 5'(DIMS);
    localparam logic [4:0] CNT_L2 = 5'(INTER);
    localparam logic [2:0] IDX_L1 = 3'(INTER - 1);
    localparam logic [2:0] IDX_L2 = 3'(CLASSES - 1);

    state_t        state, state_nxt;
    logic [4:0]    cnt, op_idx;
    logic [2:0]    idx;
    T              x [DIMS];
    T              h [INTER];
    T              y [CLASSES];
    logic [AW-1:0] addr_q, issue_addr;
    logic          w_en, din_ready, class_valid;
    logic          p_vld, p_load, p_last, p_l2;
    logic [2:0]    p_dst;
    T              p_op;
    logic [15:0]   mac_res;
    logic [1:0]    class_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        w_en        = 1'b0;
        din_ready   = 1'b0;
        class_valid = 1'b0;
        case (state)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid_i) state_nxt = (cnt == CNT_LD) ? S_L1 : S_LOAD;
            end
            S_LOAD: begin
                din_ready = 1'b1;
                if (din_valid_i && cnt == CNT_LD) state_nxt = S_L1;
            end
            S_L1: begin
                w_en = 1'b1;
                if (cnt == CNT_L1 && idx == IDX_L1) state_nxt = S_DR1;
            end
            S_DR1: state_nxt = S_L2;
            S_L2: begin
                w_en = 1'b1;
                if (cnt == CNT_L2 && idx == IDX_L2) state_nxt = S_DR2;
            end
            S_DR2:  state_nxt = S_VOTE;
            S_VOTE: state_nxt = S_OUT;
            S_OUT: begin
                class_valid = 1'b1;
                if (class_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt==0 is the bias issue of a neuron; cnt=k>0 is the weight for input k-1.
    always_comb begin
        issue_addr = addr_q;
        op_idx     = (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
        if (state == S_L1)
            issue_addr = (cnt == 5'd0) ? AW'(B1_BASE + int'(idx))
                                       : AW'(W1_BASE + int'(op_idx) * INTER + int'(idx));
        else if (state == S_L2)
            issue_addr = (cnt == 5'd0) ? AW'(B2_BASE + int'(idx))
                                       : AW'(W2_BASE + int'(op_idx) * CLASSES + int'(idx));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            idx     <= '0;
            addr_q  <= '0;
            p_vld   <= 1'b0;
            p_load  <= 1'b0;
            p_last  <= 1'b0;
            p_l2    <= 1'b0;
            p_dst   <= '0;
            p_op    <= '0;
            class_q <= '0;
        end else begin
            p_vld <= w_en;
            if (din_ready && din_valid_i) begin
                x[cnt] <= din_i;
                cnt    <= (cnt == CNT_LD) ? 5'd0 : cnt + 5'd1;
            end
            if (w_en) begin
                addr_q <= issue_addr;
                p_load <= (cnt == 5'd0);
                p_op   <= (state == S_L2) ? h[op_idx[2:0]] : x[op_idx];
                p_l2   <= (state == S_L2);
                p_dst  <= idx;
                p_last <= (cnt == ((state == S_L2) ? CNT_L2 : CNT_L1));
                if (cnt == ((state == S_L2) ? CNT_L2 : CNT_L1)) begin
                    cnt <= 5'd0;
                    idx <= (idx == ((state == S_L2) ? IDX_L2 : IDX_L1)) ? 3'd0 : idx + 3'd1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end
            // The MAC result on a neuron's final weight is the truncated activation.
            if (p_vld && p_last) begin
                if (p_l2) y[p_dst[1:0]] <= mac_res;
                else      h[p_dst]      <= mac_res;
            end
            if (state == S_VOTE) class_q <= vote3(y[0], y[1], y[2]);
        end
    end

    svm_mac_acc u_mac (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (p_vld),
        .load  (p_load),
        .a     (p_op),
        .b     (w_rdata_i),
        .res   (mac_res)
    );

    assign din_ready_o   = din_ready;
    assign w_en_o        = w_en;
    assign w_addr_o      = w_en ? issue_addr : addr_q;
    assign class_valid_o = class_valid;
    assign class_o       = class_q;
    assign busy_o        = (state != S_IDLE);

endmodule

// File: tb/tb_svm_seq.sv
// tb/tb_svm_seq.sv - directed self-checking bench for svm_seq with a behavioural weight memory
module tb_svm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [15:0] din = '0;
    logic        din_ready_o;
    logic        w_en_o;
    logic [7:0]  w_addr_o;
    logic [15:0] w_rdata = '0;
    logic        class_valid_o;
    logic [1:0]  class_o;
    logic        class_ready = 1'b0;
    logic        busy_o;

    logic [15:0] wmem [256];
    logic [15:0] xv [21];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tr_addr [$];
    int          tr_cyc [$];

    svm_seq #(.AW(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .din_valid_i   (din_valid),
        .din_i         (din),
        .din_ready_o   (din_ready_o),
        .w_en_o        (w_en_o),
        .w_addr_o      (w_addr_o),
        .w_rdata_i     (w_rdata),
        .class_valid_o (class_valid_o),
        .class_o       (class_o),
        .class_ready_i (class_ready),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (w_en_o) w_rdata <= wmem[w_addr_o];
    end

    always @(negedge clk) begin
        if (w_en_o) begin
            tr_addr.push_back(int'(w_addr_o));
            tr_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_din_ready"}, 32'(din_ready_o), 32'd1);
        check({tag, "_w_en"}, 32'(w_en_o), 32'd0);
        check({tag, "_w_addr"}, 32'(w_addr_o), 32'd0);
        check({tag, "_class_valid"}, 32'(class_valid_o), 32'd0);
        check({tag, "_class"}, 32'(class_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) wmem[a] = 16'h0000;
    endtask

    task automatic feed(input int n);
        for (int d = 0; d < n; d++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din       = xv[d];
        end
    endtask

    task automatic run(input string tag, input logic [1:0] exp_cls);
        int n;
        logic got;
        tr_addr.delete();
        tr_cyc.delete();
        feed(21);
        @(posedge clk);
        #1 din_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk);
            n++;
            #1 got = class_valid_o;
        end
        check({tag, "_latency"}, 32'(n), 32'd156);
        check({tag, "_class"}, 32'(class_o), 32'(exp_cls));
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        din_valid   = 1'b0;
        class_ready = 1'b1;
        @(negedge clk);
        class_ready = 1'b0;
        check({tag, "_ack_din_ready"}, 32'(din_ready_o), 32'd1);
        check({tag, "_ack_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int mism, gaps, bad, k;
        int exp_tr [$];
        for (int d = 0; d < 21; d++) xv[d] = 16'(d * 37 + 5);
        clear_mem();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("reset");

        // Zero weights: all y=0, class 2; also check the issue address/cycle trace.
        run("zero", 2'd2);
        for (int i = 0; i < 6; i++) begin
            exp_tr.push_back(126 + i);
            for (int d = 0; d < 21; d++) exp_tr.push_back(d * 6 + i);
        end
        for (int c = 0; c < 3; c++) begin
            exp_tr.push_back(150 + c);
            for (int i = 0; i < 6; i++) exp_tr.push_back(132 + i * 3 + c);
        end
        check("trace_len", 32'(tr_addr.size()), 32'd153);
        mism = 0;
        gaps = 0;
        for (int j = 0; j < tr_addr.size() && j < 153; j++) begin
            if (tr_addr[j] != exp_tr[j]) mism++;
            if (j > 0) begin
                k = (j == 132) ? 2 : 1;
                if (tr_cyc[j] - tr_cyc[j-1] != k) gaps++;
            end
        end
        check("trace_addr_mismatches", 32'(mism), 32'd0);
        check("trace_gaps", 32'(gaps), 32'd0);
        ack("zero");

        // B2 = {1,1,1} -> class 0, then hold the result under backpressure.
        wmem[150] = 16'h0001;
        wmem[151] = 16'h0001;
        wmem[152] = 16'h0001;
        run("b2_pos", 2'd0);
        @(negedge clk);
        din_valid = 1'b1;
        din       = 16'h1234;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (class_o !== 2'd0 || din_ready_o !== 1'b0 || class_valid_o !== 1'b1) bad++;
        end
        check("backpressure_hold", 32'(bad), 32'd0);
        ack("b2_pos");

        wmem[150] = 16'hFFFF;
        run("b2_neg0", 2'd1);
        ack("b2_neg0");

        // Accumulation: h1 = -300 + sum(1..21) = -69, y_c = -69 * -1 = 69 -> class 0.
        clear_mem();
        for (int d = 0; d < 21; d++) begin
            xv[d]          = 16'(d + 1);
            wmem[d * 6 + 1] = 16'h0001;
        end
        wmem[127] = 16'hFED4;
        for (int c = 0; c < 3; c++) wmem[135 + c] = 16'hFFFF;
        run("accum", 2'd0);
        ack("accum");

        // Truncation and sign of the hidden activation.
        clear_mem();
        wmem[0] = 16'h0002;
        for (int c = 0; c < 3; c++) wmem[132 + c] = 16'h0001;
        xv[0] = 16'h3FFF;
        run("trunc_pos", 2'd0);
        ack("trunc_pos");
        xv[0] = 16'h7FFF;
        run("trunc_wrap", 2'd2);
        ack("trunc_wrap");

        // Abort 40 cycles into L1, then a full inference must still be correct.
        xv[0] = 16'h3FFF;
        feed(21);
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_l1");
        run("after_rst_l1", 2'd0);
        ack("after_rst_l1");

        // Abort while loading word 10.
        xv[0] = 16'h7FFF;
        feed(10);
        @(negedge clk);
        din       = xv[10];
        din_valid = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        chk_reset("rst_load");
        run("after_rst_load", 2'd2);
        ack("after_rst_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svm_seq.md
Name: svm_seq

Overview:
- Time-multiplexed sequencer for the two-layer SVM classifier datapath (DIMS→INTER→CLASSES, then pairwise one-vs-one vote).
- Replaces the fully parallel layer pair with one shared 16x16 MAC.
- Weights and biases are read from an external single-port weight memory.
- Accepts one feature vector at a time over valid/ready, sequences both layers, and returns the class over valid/ready.

Parameters:
- DIMS, 21, input feature count.
- INTER, 6, hidden-layer width.
- CLASSES, 3, output classes; the vote logic is fixed for 3.
- AW, 8, weight-memory address width; must hold the 153-entry map.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- din_valid_i  in  1  sample word valid.
- din_i  in  16  signed feature word; words arrive in order d=0..DIMS-1.
- din_ready_o  out  1  sequencer can accept a sample word.
- w_en_o  out  1  weight-memory read strobe.
- w_addr_o  out  AW  weight-memory read address.
- w_rdata_i  in  16  read data; valid exactly 1 cycle after w_en_o.
- class_valid_o  out  1  result valid.
- class_o  out  2  class index 0..2.
- class_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - din_ready_o=1, w_en_o=0, w_addr_o=0, class_valid_o=0, class_o=0, busy_o=0.
  - Word counter and accumulator = 0.
- Weight map:
  - W1[d][i] at d*INTER+i (0..125).
  - B1[i] at 126+i.
  - W2[i][c] at 132+i*CLASSES+c.
  - B2[c] at 150+c.
- FSM states: IDLE → LOAD → L1 → L2 → VOTE → OUT → IDLE.
- IDLE/LOAD:
  - din_ready_o=1.
  - Each cycle with din_valid_i && din_ready_o stores x[cnt] and increments cnt.
  - The first accepted word moves IDLE→LOAD.
  - Accepting word DIMS-1 moves to L1 in the next cycle and clears cnt.
  - din_ready_o=0 in every other state; the sample buffer is single-entry.
- L1:
  - For each i=0..INTER-1, issue B1[i] then W1[0..DIMS-1][i] on consecutive cycles: INTER*(DIMS+1)=132 back-to-back issues with no gaps.
  - One cycle after each issue: the bias loads the accumulator; each weight adds x[d]*w.
  - Products are the full signed 32-bit result; the accumulator is 32-bit and wraps.
  - h[i] = acc[15:0], a truncating wrap.
- L2:
  - Same scheme with inputs h[*].
  - For each c, issue B2[c] then W2[0..INTER-1][c]: CLASSES*(INTER+1)=21 issues.
  - y[c] = acc[15:0].
  - One drain cycle separates L1 and L2, and one follows L2.
- VOTE (1 cycle):
  - Votes: y0>0 (signed) → class 0 else class 1; y1>0 → class 0 else class 2; y2>0 → class 1 else class 2. Zero counts as not-greater.
  - Result: v0>v1 ? (v0>v2?0:2) : (v1>v2?1:2). A 1-1-1 tie resolves to 2.
  - class_o is registered at the end of VOTE.
- OUT:
  - class_valid_o=1 and class_o stable until class_ready_i is sampled high.
  - Then the FSM returns to IDLE with din_ready_o=1 in the next cycle.
  - If class_ready_i is already high on the first OUT cycle, the result transfers in 1 cycle.
- Latency: class_valid_o rises exactly 156 cycles after the cycle in which the last sample word is accepted (132 + 1 + 21 + 1 + 1).
- w_en_o is high only on issue cycles. w_addr_o holds its last value when w_en_o=0.
- din_valid_i outside IDLE/LOAD is ignored and has no side effect.
- rst_i in any state aborts immediately to the reset values. Any partial sample or partial result is discarded.

Decomposition:
- svm_pkg holds:
  - typedef T = logic[15:0] and TC.
  - DIMS, INTER, CLASSES.
  - Map base constants: W1_BASE=0, B1_BASE=126, W2_BASE=132, B2_BASE=150, and LATENCY=156.
- One sub-module, svm_mac_acc: 16x16 signed multiply, 32-bit accumulate, with load and enable inputs.
- The FSM, counters, and vote logic stay in svm_seq.

Test Plan:
- All weights/biases 0, x = arbitrary → all y=0 → votes 1,2,2 → class_o=2. class_valid_o rises exactly 156 cycles after the last accept.
- B2={1,1,1}, all else 0 → class_o=0. B2={0xFFFF,1,1} → class_o=1.
- Truncation/sign:
  - Setup: W1[0][0]=2, W2[0][c]=1 for all c, all else 0.
  - x0=0x3FFF gives y=0x7FFE, so class_o=0.
  - x0=0x7FFF gives h0=0xFFFE (-2), so class_o=2.
- Address trace: the w_addr_o sequence over one inference equals 126,0,6,12,…,120,127,1,… through 153 issues, with no w_en_o gaps inside each layer.
- Backpressure:
  - Stimulus: hold class_ready_i=0 for 10 cycles in OUT while driving din_valid_i=1.
  - Required: class_o is stable, din_ready_o=0, and no sample word is consumed.
  - After ready is given, din_ready_o=1 next cycle.
- Reset during L1 (cycle 40) and during LOAD (word 10) → all outputs at reset values next cycle. A following full sample yields a correct result.
